// File: rtl/led_pattern_monitor_if.sv
// LED bus and monitor status signals between the flasher side (master) and led_pattern_monitor (slave).
// With LMON_KICK_CNT_EN defined the bus also carries kick_count.
interface led_pattern_monitor_if #(
  parameter int CNT_W = 8
);
  logic [15:0]      leds;
  logic [2:0]       phase;
  logic             kickback;
  logic             cycle_done;
  logic [CNT_W-1:0] cycle_count;
  logic             err;
  logic [1:0]       err_code;
`ifdef LMON_KICK_CNT_EN
  logic [CNT_W-1:0] kick_count;

  modport master (
    output leds,
    input  phase, kickback, cycle_done, cycle_count, err, err_code, kick_count
  );
  modport slave (
    input  leds,
    output phase, kickback, cycle_done, cycle_count, err, err_code, kick_count
  );
`else
  modport master (
    output leds,
    input  phase, kickback, cycle_done, cycle_count, err, err_code
  );
  modport slave (
    input  leds,
    output phase, kickback, cycle_done, cycle_count, err, err_code
  );
`endif
endinterface

// File: rtl/led_pattern_monitor.sv
// Receive-side checker for the 16-bit bound-flasher LED bus: phase tracking, kickbacks, cycles, errors.
// Define LMON_KICK_CNT_EN to add the saturating kick_count output.
//  state  | meaning
//  IDLE   | all LEDs off, waiting for the first LED
//  UP1    | rising towards 6
//  DN1    | falling towards 0
//  UP2    | rising towards 11
//  DN2    | falling towards 5
//  UP3    | rising towards 16
//  DN3    | falling to 0, end of a flash cycle
//  RESYNC | after an error, waiting for all-off
module led_pattern_monitor #(
  parameter int CNT_W    = 8,
  parameter int MAX_HOLD = 2
) (
  input logic                  clk,
  input logic                  rst,
  led_pattern_monitor_if.slave bus
);
  localparam int                HOLD_W   = $clog2(MAX_HOLD + 2);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UP1    = 3'd1,
    DN1    = 3'd2,
    UP2    = 3'd3,
    DN2    = 3'd4,
    UP3    = 3'd5,
    DN3    = 3'd6,
    RESYNC = 3'd7
  } phase_t;

  phase_t            state_q, state_nxt;
  logic [4:0]        n, p_q;
  logic [HOLD_W-1:0] hold_q, hold_nxt, hold_inc;
  logic              amb_q, amb_nxt;
  logic [16:0]       leds_x;
  logic              therm, same, up, dn, jump, step_bad;
  logic              ev_err, ev_kick, ev_done;
  logic [1:0]        ev_code;
  logic              kick_q, kick_nxt, done_q, done_nxt, err_q, err_nxt;
  logic [1:0]        code_q, code_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
`ifdef LMON_KICK_CNT_EN
  logic [CNT_W-1:0]  kcnt_q, kcnt_nxt;
`endif

  always_comb begin
    n = 5'd0;
    for (int i = 0; i < 16; i++) n = n + {4'd0, bus.leds[i]};
  end

  // A thermometer code has no set bit above a clear bit, so adding one only carries out.
  assign leds_x   = {1'b0, bus.leds};
  assign therm    = ((leds_x & (leds_x + 17'd1)) == 17'd0);
  assign same     = (n == p_q);
  assign up       = (n == p_q + 5'd1);
  assign dn       = (n + 5'd1 == p_q);
  assign jump     = !(same || up || dn);
  assign hold_inc = hold_q + HOLD_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= 5'd0;
      hold_q  <= '0;
      amb_q   <= 1'b0;
      kick_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
      cnt_q   <= '0;
`ifdef LMON_KICK_CNT_EN
      kcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_nxt;
      p_q     <= n;
      hold_q  <= hold_nxt;
      amb_q   <= amb_nxt;
      kick_q  <= kick_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
      code_q  <= code_nxt;
      cnt_q   <= cnt_nxt;
`ifdef LMON_KICK_CNT_EN
      kcnt_q  <= kcnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state_q;
    amb_nxt   = amb_q;
    hold_nxt  = hold_q;
    step_bad  = 1'b0;
    ev_err    = 1'b0;
    ev_code   = 2'd0;
    ev_kick   = 1'b0;
    ev_done   = 1'b0;
    if (state_q == RESYNC) begin
      hold_nxt = '0;
      if (n == 5'd0) state_nxt = IDLE;
    end else if (!therm) begin
      ev_err  = 1'b1;
      ev_code = 2'd1;
    end else if (same) begin
      if (state_q != IDLE) begin
        hold_nxt = hold_inc;
        if (hold_inc > HOLD_MAX) begin
          ev_err  = 1'b1;
          ev_code = 2'd3;
        end
      end
    end else if (jump) begin
      ev_err  = 1'b1;
      ev_code = 2'd2;
    end else begin
      hold_nxt = '0;
      case (state_q)
        IDLE: begin
          if (n == 5'd1) state_nxt = UP1;
          else step_bad = 1'b1;
        end
        UP1: begin
          if (up && n <= 5'd6) state_nxt = UP1;
          else if (p_q == 5'd6 && n == 5'd5) state_nxt = DN1;
          else step_bad = 1'b1;
        end
        DN1: begin
          if (dn) state_nxt = DN1;
          else if (p_q == 5'd0 && n == 5'd1) state_nxt = UP2;
          else step_bad = 1'b1;
        end
        UP2: begin
          if (up && n <= 5'd11) state_nxt = UP2;
          else if (p_q == 5'd6 && n == 5'd5) begin
            state_nxt = DN1;
            ev_kick   = 1'b1;
          end else if (p_q == 5'd11 && n == 5'd10) begin
            // A turn at 11 may be the natural peak or a kickback; decided at the DN2 valley.
            state_nxt = DN2;
            amb_nxt   = 1'b1;
          end else step_bad = 1'b1;
        end
        DN2: begin
          if (dn && n >= 5'd5) state_nxt = DN2;
          else if (p_q == 5'd5 && n == 5'd6) begin
            state_nxt = UP3;
            amb_nxt   = 1'b0;
          end else if (p_q == 5'd5 && n == 5'd4 && amb_q) begin
            state_nxt = DN1;
            amb_nxt   = 1'b0;
            ev_kick   = 1'b1;
          end else step_bad = 1'b1;
        end
        UP3: begin
          if (up) state_nxt = UP3;
          else if ((p_q == 5'd6 && n == 5'd5) || (p_q == 5'd11 && n == 5'd10)) begin
            state_nxt = DN2;
            amb_nxt   = 1'b0;
            ev_kick   = 1'b1;
          end else if (p_q == 5'd16 && n == 5'd15) state_nxt = DN3;
          else step_bad = 1'b1;
        end
        DN3: begin
          if (dn) begin
            if (n == 5'd0) begin
              state_nxt = IDLE;
              ev_done   = 1'b1;
            end
          end else step_bad = 1'b1;
        end
        default: step_bad = 1'b0;
      endcase
      if (step_bad) begin
        ev_err  = 1'b1;
        ev_code = 2'd2;
      end
    end
    if (ev_err) begin
      state_nxt = RESYNC;
      amb_nxt   = 1'b0;
      hold_nxt  = '0;
    end
  end

  always_comb begin
    kick_nxt = ev_kick;
    done_nxt = ev_done;
    err_nxt  = err_q | ev_err;
    code_nxt = (ev_err && !err_q) ? ev_code : code_q;
    cnt_nxt  = (ev_done && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
`ifdef LMON_KICK_CNT_EN
    kcnt_nxt = (ev_kick && !(&kcnt_q)) ? kcnt_q + 1'b1 : kcnt_q;
`endif
  end

  assign bus.phase       = state_q;
  assign bus.kickback    = kick_q;
  assign bus.cycle_done  = done_q;
  assign bus.cycle_count = cnt_q;
  assign bus.err         = err_q;
  assign bus.err_code    = code_q;
`ifdef LMON_KICK_CNT_EN
  assign bus.kick_count  = kcnt_q;
`endif
endmodule

// File: tb/tb_led_pattern_monitor.sv
// Scoreboard bench for led_pattern_monitor: directed flasher sequences plus randomized traffic,
// checked against a peak/valley rule model; a CNT_W=2 copy exercises counter saturation.
module tb_led_pattern_monitor;
  localparam int MAX_HOLD = 2;

  typedef struct {
    int phase;
    int kick;
    int done;
    int cnt8;
    int cnt2;
    int err;
    int code;
    int kcnt8;
    int kcnt2;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_pattern_monitor_if #(.CNT_W(8)) bus8 ();
  led_pattern_monitor_if #(.CNT_W(2)) bus2 ();

  led_pattern_monitor #(.CNT_W(8), .MAX_HOLD(MAX_HOLD)) u_dut (.clk(clk), .rst(rst), .bus(bus8));
  led_pattern_monitor #(.CNT_W(2), .MAX_HOLD(MAX_HOLD)) u_sat (.clk(clk), .rst(rst), .bus(bus2));

  int checks = 0;
  int errors = 0;
  exp_t expq[$];

  // Reference model state; phases 1..6 alternate direction between fixed peaks and valleys.
  int DIR[7] = '{0, 1, -1, 1, -1, 1, -1};
  int LIM[7] = '{0, 6, 0, 11, 5, 16, 0};
  int m_phase, m_p, m_hold, m_amb, m_err, m_code, m_cnt8, m_cnt2, m_kcnt8, m_kcnt2;
  bit m_kick, m_done;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] therm(input int k);
    logic [31:0] t;
    t = (32'd1 << k) - 32'd1;
    return t[15:0];
  endfunction

  task automatic model_move(input int n, output int e);
    int d;
    d = n - m_p;
    e = 0;
    if (m_phase == 0) begin
      if (n == 1) m_phase = 1;
      else e = 2;
    end else if (d == DIR[m_phase] && (d > 0 ? n <= LIM[m_phase] : n >= LIM[m_phase])) begin
      if (m_phase == 6 && n == 0) begin
        m_phase = 0;
        m_done  = 1;
      end
    end else if (d == -DIR[m_phase] && m_p == LIM[m_phase]) begin
      m_amb   = (m_phase == 3) ? 1 : 0;
      m_phase = m_phase + 1;
    end else if (d < 0 && ((m_phase == 3 && m_p == 6) ||
                           (m_phase == 5 && (m_p == 6 || m_p == 11)))) begin
      m_phase = m_phase - 1;
      m_amb   = 0;
      m_kick  = 1;
    end else if (m_phase == 4 && m_p == 5 && n == 4 && m_amb == 1) begin
      m_phase = 2;
      m_amb   = 0;
      m_kick  = 1;
    end else e = 2;
  endtask

  task automatic model_step(input logic r, input logic [15:0] v);
    exp_t x;
    int n, e;
    m_kick = 0;
    m_done = 0;
    if (r) begin
      m_phase = 0; m_p = 0; m_hold = 0; m_amb = 0; m_err = 0; m_code = 0;
      m_cnt8 = 0; m_cnt2 = 0; m_kcnt8 = 0; m_kcnt2 = 0;
    end else begin
      n = $countones(v);
      e = 0;
      if (m_phase == 7) begin
        if (n == 0) m_phase = 0;
        m_hold = 0;
      end else begin
        if (int'(v) != (1 << n) - 1) e = 1;
        else if (n == m_p) begin
          if (m_phase != 0) begin
            m_hold++;
            if (m_hold > MAX_HOLD) e = 3;
          end
        end else begin
          m_hold = 0;
          if (n - m_p > 1 || m_p - n > 1) e = 2;
          else model_move(n, e);
        end
        if (e != 0) begin
          if (m_err == 0) m_code = e;
          m_err = 1; m_phase = 7; m_amb = 0; m_hold = 0;
        end
      end
      m_p = n;
      if (m_done) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (m_kick) begin
        if (m_kcnt8 < 255) m_kcnt8++;
        if (m_kcnt2 < 3) m_kcnt2++;
      end
    end
    x.phase = m_phase; x.kick = int'(m_kick); x.done = int'(m_done);
    x.cnt8 = m_cnt8; x.cnt2 = m_cnt2; x.err = m_err; x.code = m_code;
    x.kcnt8 = m_kcnt8; x.kcnt2 = m_kcnt2;
    expq.push_back(x);
  endtask

  task automatic drive(input logic r, input logic [15:0] v);
    @(negedge clk);
    rst = r;
    bus8.leds = v;
    bus2.leds = v;
    model_step(r, v);
  endtask

  task automatic send(input int k);
    drive(1'b0, therm(k));
  endtask

  task automatic ramp(input int a, input int b);
    int s;
    s = (a < b) ? 1 : -1;
    for (int k = a + s; k != b + s; k += s) send(k);
  endtask

  task automatic clean_cycle();
    ramp(0, 6); ramp(6, 0); ramp(0, 11); ramp(11, 5); ramp(5, 16); ramp(16, 0);
  endtask

  function automatic int natural_next();
    int p;
    p = m_p;
    case (m_phase)
      0: return ($urandom_range(0, 4) == 0) ? 0 : 1;
      1: return (p < 6) ? p + 1 : 5;
      2: return (p > 0) ? p - 1 : 1;
      3: if (p == 6 && $urandom_range(0, 3) == 0) return 5;
         else return (p < 11) ? p + 1 : 10;
      4: if (p > 5) return p - 1;
         else return (m_amb == 1 && $urandom_range(0, 1) == 1) ? 4 : 6;
      5: if ((p == 6 || p == 11) && $urandom_range(0, 4) == 0) return p - 1;
         else return (p < 16) ? p + 1 : 15;
      6: return p - 1;
      default: return ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(0, 16));
    endcase
  endfunction

  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        x = expq.pop_front();
        chk("phase", int'(bus8.phase), x.phase);
        chk("kickback", int'(bus8.kickback), x.kick);
        chk("cycle_done", int'(bus8.cycle_done), x.done);
        chk("cycle_count", int'(bus8.cycle_count), x.cnt8);
        chk("err", int'(bus8.err), x.err);
        chk("err_code", int'(bus8.err_code), x.code);
        chk("sat_phase", int'(bus2.phase), x.phase);
        chk("sat_cycle_done", int'(bus2.cycle_done), x.done);
        chk("sat_cycle_count", int'(bus2.cycle_count), x.cnt2);
        chk("sat_err_code", int'(bus2.err_code), x.code);
`ifdef LMON_KICK_CNT_EN
        chk("kick_count", int'(bus8.kick_count), x.kcnt8);
        chk("sat_kick_count", int'(bus2.kick_count), x.kcnt2);
`endif
      end
    end
  end

  initial begin
    int r, k;
    logic [15:0] v;
    logic rr;
    bus8.leds = 16'h0;
    bus2.leds = 16'h0;
    repeat (3) drive(1'b1, 16'h0);
    send(0); send(0);
    clean_cycle();
    send(0);
    // UP2 kickback at 6, then the rest of the cycle
    ramp(0, 6); ramp(6, 0); ramp(0, 6); ramp(6, 0); ramp(0, 11); ramp(11, 5); ramp(5, 16); ramp(16, 0);
    // deferred kickback at 11 resolved at the DN2 valley
    ramp(0, 6); ramp(6, 0); ramp(0, 11); ramp(11, 4); ramp(4, 0);
    ramp(0, 11); ramp(11, 5); ramp(5, 16); ramp(16, 0);
    // UP3 kickback at 11
    ramp(0, 6); ramp(6, 0); ramp(0, 11); ramp(11, 5); ramp(5, 11); ramp(11, 5); ramp(5, 16); ramp(16, 0);
    // non-thermometer mid-UP1, later jump in RESYNC, recovery
    ramp(0, 3);
    drive(1'b0, 16'h0005);
    send(3); send(5); send(0); send(0);
    // stall in UP1
    drive(1'b1, 16'h0);
    ramp(0, 4);
    for (int i = 0; i < MAX_HOLD + 1; i++) send(4);
    send(0);
    // saturation of the narrow counter
    drive(1'b1, 16'h0);
    repeat (4) clean_cycle();
    send(0);
    for (int i = 0; i < 3000; i++) begin
      r  = int'($urandom_range(0, 199));
      rr = 1'b0;
      if (r < 2) begin
        rr = 1'b1;
        v  = 16'($urandom);
      end else if (r < 7) v = 16'($urandom);
      else if (r < 13) v = therm(m_p);
      else if (r < 16) v = therm(int'($urandom_range(0, 16)));
      else begin
        k = natural_next();
        v = therm(k);
      end
      drive(rr, v);
    end
    for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
    #2;
    chk("scoreboard_drain", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
